// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the decode-to-execute control pipeline.
package ctrl_pipe_pkg;

  // Control bundle from decode to execute. The packed struct is 17 bits wide.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
    logic [2:0] funct3;
    logic [2:0] imm_src;
  } ctrl_de_t;

  localparam int CTRL_DE_W = 17;

  // An all-zero bundle is a NOP. It performs no register write, no memory write,
  // no jump and no branch.
  localparam ctrl_de_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_slot.sv
// One elastic pipeline slot. It holds a valid flag and a data register.
// When the slot is empty or flushed it holds the bubble value.
module ctrl_pipe_slot
  import ctrl_pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = CTRL_DE_W,
  parameter logic [DATA_WIDTH-1:0] BUBBLE     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  // Flush overrides load. A load of an invalid source stores the bubble,
  // so consumers that ignore valid still see a NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (load) begin
      valid <= in_valid;
      data  <= in_valid ? in_data : BUBBLE;
    end
  end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// Elastic control-bundle pipeline of DEPTH slots with a valid/ready handshake.
// Features: stall back-pressure, synchronous flush and bubble collapsing.
// The ready chain is purely combinational: ready_i = !valid_i | ready_(i+1).
// It is computed in closed form to avoid a self-referencing vector.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = CTRL_DE_W,
  parameter int                    DEPTH      = 1,
  parameter logic [DATA_WIDTH-1:0] BUBBLE     = '0,
  localparam int                   OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DEPTH-1:0]      slot_valid;
  logic [DEPTH-1:0]      slot_ready;
  logic [DEPTH-1:0]      src_valid;
  logic [DATA_WIDTH-1:0] slot_data [DEPTH];
  logic [DATA_WIDTH-1:0] src_data  [DEPTH];
  logic                  push;
  logic                  pop;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    // Slot i can advance when downstream accepts, or when any slot at or after i is empty.
    assign slot_ready[i] = out_ready | ~(&slot_valid[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign src_valid[i] = in_valid;
      assign src_data[i]  = in_data;
    end else begin : g_body
      assign src_valid[i] = slot_valid[i-1];
      assign src_data[i]  = slot_data[i-1];
    end

    ctrl_pipe_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUBBLE     (BUBBLE)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (slot_ready[i]),
      .in_valid (src_valid[i]),
      .in_data  (src_data[i]),
      .valid    (slot_valid[i]),
      .data     (slot_data[i])
    );
  end

  assign in_ready  = slot_ready[0];
  assign out_valid = slot_valid[DEPTH-1];
  assign out_data  = slot_data[DEPTH-1];

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Registered occupancy count. Flush clears it. A push and a pop in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (push && !pop) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (pop && !push) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Bench for ctrl_pipe_stage. Three instances (DEPTH 1, 2 and 3) share one stimulus stream.
// Each instance is compared against its own slot-array reference model.
module tb_ctrl_pipe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [16:0] in_data = '0;

  logic        ir  [3];
  logic        ov  [3];
  logic [16:0] od  [3];
  logic [3:0]  occ [3];
  logic [0:0]  occ1;
  logic [1:0]  occ2;
  logic [1:0]  occ3;

  int total = 0;
  int bad   = 0;

  int          dep [3] = '{1, 2, 3};
  logic        mv  [3][8];
  logic [16:0] md  [3][8];

  always #5 clk = ~clk;

  ctrl_pipe_stage #(.DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(occ1));
  ctrl_pipe_stage #(.DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(occ2));
  ctrl_pipe_stage #(.DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .occupancy(occ3));

  assign occ[0] = {3'b0, occ1};
  assign occ[1] = {2'b0, occ2};
  assign occ[2] = {2'b0, occ3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 8; j++) begin
        mv[k][j] = 1'b0;
        md[k][j] = '0;
      end
  endtask

  function automatic int m_count(input int k);
    int n = 0;
    for (int j = 0; j < dep[k]; j++) if (mv[k][j]) n++;
    return n;
  endfunction

  // Input is accepted if the output drains this cycle, or if any slot is empty.
  function automatic logic m_in_ready(input int k);
    logic r = out_ready;
    for (int j = 0; j < dep[k]; j++) if (!mv[k][j]) r = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (flush) begin
        for (int j = 0; j < 8; j++) begin
          mv[k][j] = 1'b0;
          md[k][j] = '0;
        end
      end else begin
        logic move [8];
        for (int i = 0; i < 8; i++) move[i] = 1'b0;
        for (int i = 0; i < dep[k]; i++) begin
          move[i] = out_ready;
          for (int j = i; j < dep[k]; j++) if (!mv[k][j]) move[i] = 1'b1;
        end
        for (int i = dep[k] - 1; i >= 0; i--) begin
          if (move[i]) begin
            if (i == 0) begin
              mv[k][0] = in_valid;
              md[k][0] = in_valid ? in_data : 17'h0;
            end else begin
              mv[k][i] = mv[k][i-1];
              md[k][i] = mv[k][i-1] ? md[k][i-1] : 17'h0;
            end
          end
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [16:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_valid_d%0d", dep[k]), 32'(ov[k]), 32'(mv[k][dep[k]-1]));
      chk($sformatf("out_data_d%0d", dep[k]), 32'(od[k]), 32'(md[k][dep[k]-1]));
      chk($sformatf("occupancy_d%0d", dep[k]), 32'(occ[k]), 32'(m_count(k)));
    end
  endtask

  // One clock: check in_ready before the edge, advance the model at the edge, then check outputs.
  task automatic step();
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("in_ready_d%0d", dep[k]), 32'(ir[k]), 32'(m_in_ready(k)));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", 32'(ov[k]), 32'h0);
      chk("rst_out_data", 32'(od[k]), 32'h0);
      chk("rst_occupancy", 32'(occ[k]), 32'h0);
    end
    rst = 1'b1;
  endtask

  initial begin
    model_clear();
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("init_out_valid", 32'(ov[k]), 32'h0);
      chk("init_out_data", 32'(od[k]), 32'h0);
      chk("init_occupancy", 32'(occ[k]), 32'h0);
    end
    rst = 1'b1;

    // Reset mid-stream: two bundles in flight, then reset between edges.
    drive(1'b1, 17'h00011, 1'b0, 1'b0); step();
    drive(1'b1, 17'h00022, 1'b0, 1'b0); step();
    chk("pre_reset_occ_d2", 32'(occ[1]), 32'h2);
    async_reset();

    // Stream: back-to-back pushes with no stall.
    drive(1'b1, 17'h00011, 1'b1, 1'b0); step();
    drive(1'b1, 17'h00022, 1'b1, 1'b0); step();
    chk("stream_d2_first", 32'(od[1]), 32'h00011);
    drive(1'b1, 17'h00033, 1'b1, 1'b0); step();
    chk("stream_d2_second", 32'(od[1]), 32'h00022);
    drive(1'b0, 17'h0, 1'b1, 1'b0); step();
    chk("stream_d2_third", 32'(od[1]), 32'h00033);
    chk("stream_d2_valid", 32'(ov[1]), 32'h1);
    for (int n = 0; n < 3; n++) step();

    // Stall: fill, hold for five cycles, then release.
    drive(1'b1, 17'h00011, 1'b0, 1'b0); step();
    drive(1'b1, 17'h00022, 1'b0, 1'b0); step();
    drive(1'b1, 17'h00055, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("stall_in_ready_d2", 32'(ir[1]), 32'h0);
      chk("stall_hold_d2", 32'(od[1]), 32'h00011);
    end
    drive(1'b0, 17'h0, 1'b1, 1'b0); step();
    chk("release_d2", 32'(od[1]), 32'h00022);
    for (int n = 0; n < 4; n++) step();

    // Collapse: the tail is stalled, yet upstream bubbles still fill.
    drive(1'b1, 17'h00011, 1'b0, 1'b0); step();
    drive(1'b0, 17'h0, 1'b0, 1'b0); step();
    step();
    chk("collapse_tail_d3", 32'(od[2]), 32'h00011);
    drive(1'b1, 17'h00022, 1'b0, 1'b0); step();
    drive(1'b1, 17'h00033, 1'b0, 1'b0); step();
    chk("collapse_occ_d3", 32'(occ[2]), 32'h3);
    chk("collapse_full_d3", 32'(ir[2]), 32'h0);

    // Flush: the input offered in the flush cycle is dropped.
    chk("preflush_occ_d2", 32'(occ[1]), 32'h2);
    drive(1'b1, 17'h1ABCD, 1'b1, 1'b1); step();
    for (int k = 0; k < 3; k++) chk("flush_occ", 32'(occ[k]), 32'h0);
    drive(1'b0, 17'h0, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) step();

    // DEPTH=1 full with pop and push in the same cycle.
    drive(1'b1, 17'h00101, 1'b1, 1'b0); step();
    drive(1'b1, 17'h00202, 1'b1, 1'b0); step();
    chk("poppush_occ_d1", 32'(occ[0]), 32'h1);
    chk("poppush_data_d1", 32'(od[0]), 32'h00202);
    drive(1'b1, 17'h00303, 1'b1, 1'b0); step();
    chk("poppush_data2_d1", 32'(od[0]), 32'h00303);

    // Randomized traffic with occasional flushes and one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 17'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      step();
      if (n == 200) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
